// File: rtl/dda_result_fifo.sv
// dda_result_fifo: first-word-fall-through elastic buffer carrying 48-bit DDA
// ray results to the transformation stage, with end-of-frame and overflow flags.
module dda_result_fifo #(
  parameter int DEPTH        = 16,
  parameter int SCREEN_WIDTH = 320
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [10:0]              hcount_ray_in,
  input  logic [15:0]              lineHeight_in,
  input  logic                     wallType_in,
  input  logic [3:0]               mapData_in,
  input  logic [15:0]              wallX_in,
  input  logic                     ray_valid_in,
  output logic                     ray_ready_out,
  output logic [10:0]              hcount_ray_out,
  output logic [15:0]              lineHeight_out,
  output logic                     wallType_out,
  output logic [3:0]               mapData_out,
  output logic [15:0]              wallX_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     frame_done_out,
  output logic                     overflow_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [47:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [47:0]   wr_rec;
  logic [47:0]   head_rec;
  logic          push;
  logic          pop;

  // Ready comes only from the registered count, so ready_in never reaches it.
  assign ray_ready_out = (count < CW'(DEPTH));
  assign valid_out     = (count != '0);
  assign count_out     = count;

  assign push = ray_valid_in && ray_ready_out;
  assign pop  = valid_out && ready_in;

  assign wr_rec   = {hcount_ray_in, lineHeight_in, wallType_in, mapData_in, wallX_in};
  assign head_rec = mem[rd_ptr];

  // Head record is presented directly; forced to zero while empty or in reset.
  always_comb begin
    {hcount_ray_out, lineHeight_out, wallType_out, mapData_out, wallX_out} = '0;
    if (valid_out) begin
      {hcount_ray_out, lineHeight_out, wallType_out, mapData_out, wallX_out} = head_rec;
    end
  end

  // Record storage; contents need no reset since emptiness gates the outputs.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= wr_rec;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag and a one-cycle pulse when the frame's last column leaves.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      overflow_out   <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      if (ray_valid_in && !ray_ready_out) overflow_out <= 1'b1;
      frame_done_out <= pop && (hcount_ray_out == 11'(SCREEN_WIDTH - 1));
    end
  end

endmodule

// File: tb/tb_dda_result_fifo.sv
// tb_dda_result_fifo: table vectors, hand sequences and randomized traffic
// checked against a queue-based reference model of the buffer.
module tb_dda_result_fifo;

  localparam int DEPTH = 16;
  localparam int SW    = 320;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] hcount_ray_in = '0;
  logic [15:0] lineHeight_in = '0;
  logic        wallType_in = 1'b0;
  logic [3:0]  mapData_in = '0;
  logic [15:0] wallX_in = '0;
  logic        ray_valid_in = 1'b0;
  logic        ray_ready_out;
  logic [10:0] hcount_ray_out;
  logic [15:0] lineHeight_out;
  logic        wallType_out;
  logic [3:0]  mapData_out;
  logic [15:0] wallX_out;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic [4:0]  count_out;
  logic        frame_done_out;
  logic        overflow_out;

  dda_result_fifo #(.DEPTH(DEPTH), .SCREEN_WIDTH(SW)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .hcount_ray_in(hcount_ray_in), .lineHeight_in(lineHeight_in),
    .wallType_in(wallType_in), .mapData_in(mapData_in), .wallX_in(wallX_in),
    .ray_valid_in(ray_valid_in), .ray_ready_out(ray_ready_out),
    .hcount_ray_out(hcount_ray_out), .lineHeight_out(lineHeight_out),
    .wallType_out(wallType_out), .mapData_out(mapData_out), .wallX_out(wallX_out),
    .valid_out(valid_out), .ready_in(ready_in), .count_out(count_out),
    .frame_done_out(frame_done_out), .overflow_out(overflow_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: records held, sticky overflow, expected frame pulse.
  logic [47:0] rq[$];
  bit          m_ovf = 1'b0;
  bit          m_fd  = 1'b0;

  function automatic logic [47:0] mk(input logic [10:0] hc, input logic [15:0] lh,
                                     input logic wt, input logic [3:0] md,
                                     input logic [15:0] wx);
    return {hc, lh, wt, md, wx};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("ready", 64'(ray_ready_out), 64'(rq.size() < DEPTH));
    chk("valid", 64'(valid_out), 64'(rq.size() != 0));
    chk("count", 64'(count_out), 64'(rq.size()));
    chk("overflow", 64'(overflow_out), 64'(m_ovf));
    chk("frame_done", 64'(frame_done_out), 64'(m_fd));
    if (rq.size() != 0) begin
      chk("head_rec", 64'({hcount_ray_out, lineHeight_out, wallType_out, mapData_out, wallX_out}),
          64'(rq[0]));
    end
  endtask

  // One clock: drive inputs, advance model by the handshake rules, then compare.
  task automatic cycle(input bit vin, input logic [47:0] rec, input bit rin);
    bit m_ready, m_valid, do_push, do_pop;
    ray_valid_in = vin;
    {hcount_ray_in, lineHeight_in, wallType_in, mapData_in, wallX_in} = rec;
    ready_in = rin;
    m_ready = rq.size() < DEPTH;
    m_valid = rq.size() != 0;
    do_push = vin && m_ready;
    do_pop  = m_valid && rin;
    @(posedge clk_in);
    m_fd = do_pop && (rq[0][47:37] == 11'(SW - 1));
    if (do_pop) void'(rq.pop_front());
    if (do_push) rq.push_back(rec);
    if (vin && !m_ready) m_ovf = 1'b1;
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    ray_valid_in = 1'b0;
    ready_in = 1'b0;
    rq.delete();
    m_ovf = 1'b0;
    m_fd = 1'b0;
    #2;
    chk("rst_valid", 64'(valid_out), 64'(0));
    chk("rst_count", 64'(count_out), 64'(0));
    chk("rst_overflow", 64'(overflow_out), 64'(0));
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  typedef struct {
    bit          vin;
    bit          rin;
    logic [47:0] rec;
    bit          e_valid;
    int          e_count;
    logic [10:0] e_hc;
    bit          e_fd;
  } vec_t;

  vec_t tbl[11];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [47:0] r;
    // Single record, then frame boundary columns 317,318,319,0.
    tbl[0]  = '{1, 0, mk(11'd5, 16'h0120, 1'b1, 4'd3, 16'h8000), 1, 1, 11'd5, 0};
    tbl[1]  = '{0, 1, '0, 0, 0, 11'd0, 0};
    tbl[2]  = '{1, 0, mk(11'd317, 16'h0011, 1'b0, 4'd1, 16'h0101), 1, 1, 11'd317, 0};
    tbl[3]  = '{1, 0, mk(11'd318, 16'h0022, 1'b1, 4'd2, 16'h0202), 1, 2, 11'd317, 0};
    tbl[4]  = '{1, 0, mk(11'd319, 16'h0033, 1'b0, 4'd3, 16'h0303), 1, 3, 11'd317, 0};
    tbl[5]  = '{1, 0, mk(11'd0,   16'h0044, 1'b1, 4'd4, 16'h0404), 1, 4, 11'd317, 0};
    tbl[6]  = '{0, 1, '0, 1, 3, 11'd318, 0};
    tbl[7]  = '{0, 1, '0, 1, 2, 11'd319, 0};
    tbl[8]  = '{0, 1, '0, 1, 1, 11'd0, 1};
    tbl[9]  = '{0, 1, '0, 0, 0, 11'd0, 0};
    tbl[10] = '{0, 0, '0, 0, 0, 11'd0, 0};

    // Power-on reset state.
    repeat (2) @(posedge clk_in);
    #1;
    chk("por_valid", 64'(valid_out), 64'(0));
    chk("por_ready", 64'(ray_ready_out), 64'(1));
    chk("por_count", 64'(count_out), 64'(0));
    chk("por_fd", 64'(frame_done_out), 64'(0));
    chk("por_ovf", 64'(overflow_out), 64'(0));
    chk("por_data", 64'(hcount_ray_out), 64'(0));
    rst_in = 1'b0;

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].vin, tbl[i].rec, tbl[i].rin);
      chk($sformatf("tbl%0d_valid", i), 64'(valid_out), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_count", i), 64'(count_out), 64'(tbl[i].e_count));
      chk($sformatf("tbl%0d_fd", i), 64'(frame_done_out), 64'(tbl[i].e_fd));
      if (tbl[i].e_valid)
        chk($sformatf("tbl%0d_hc", i), 64'(hcount_ray_out), 64'(tbl[i].e_hc));
    end

    // Fill to full, then overflow with column 99, then drain in order.
    for (int i = 0; i < 16; i++) cycle(1, mk(11'(i), 16'(i * 7), 1'(i), 4'(i), 16'(i * 13)), 0);
    chk("full_ready", 64'(ray_ready_out), 64'(0));
    chk("full_count", 64'(count_out), 64'(16));
    cycle(1, mk(11'd99, 16'hdead, 1'b1, 4'hf, 16'hbeef), 0);
    chk("ovf_set", 64'(overflow_out), 64'(1));
    chk("ovf_count", 64'(count_out), 64'(16));
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_hc", i), 64'(hcount_ray_out), 64'(i));
      cycle(0, '0, 1);
    end
    chk("drain_empty", 64'(valid_out), 64'(0));

    // Full with simultaneous pop and attempted push: push refused.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, mk(11'(i + 40), 16'(i), 1'b0, 4'(i), 16'(i)), 0);
    cycle(1, mk(11'd200, 16'h1, 1'b1, 4'h1, 16'h1), 1);
    chk("fullpp_count", 64'(count_out), 64'(15));
    chk("fullpp_ovf", 64'(overflow_out), 64'(1));
    chk("fullpp_head", 64'(hcount_ray_out), 64'(41));

    // Continuous streaming, 40 records, pointers wrap twice.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cycle(1, mk(11'(i + 100), 16'(i * 5), 1'(i >> 1), 4'(i), 16'(i * 977)), 1);
      chk($sformatf("stream%0d_count", i), 64'(count_out), 64'(1));
      chk($sformatf("stream%0d_hc", i), 64'(hcount_ray_out), 64'(i + 100));
    end
    chk("stream_ovf", 64'(overflow_out), 64'(0));
    cycle(0, '0, 1);

    // Randomized traffic in phases of differing downstream pressure.
    do_reset();
    for (int ph = 0; ph < 6; ph++) begin
      int unsigned pv, pr;
      pv = (ph % 2 == 0) ? 70 : 40;
      pr = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 55 : 90);
      for (int i = 0; i < 250; i++) begin
        logic [10:0] hc;
        hc = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(316, 319))
                                          : 11'($urandom_range(0, SW - 1));
        r = mk(hc, 16'($urandom), 1'($urandom), 4'($urandom), 16'($urandom));
        cycle($urandom_range(0, 99) < pv, r, $urandom_range(0, 99) < pr);
      end
    end

    // Asynchronous reset between edges with 7 records held.
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1, mk(11'(i + 300), 16'(i), 1'b0, 4'(i), 16'(i)), 0);
    chk("pre_arst_count", 64'(count_out), 64'(7));
    @(negedge clk_in);
    #1;
    rst_in = 1'b1;
    #1;
    chk("arst_valid", 64'(valid_out), 64'(0));
    chk("arst_count", 64'(count_out), 64'(0));
    chk("arst_ovf", 64'(overflow_out), 64'(0));
    chk("arst_ready", 64'(ray_ready_out), 64'(1));
    rq.delete();
    m_ovf = 1'b0;
    m_fd = 1'b0;
    ray_valid_in = 1'b0;
    ready_in = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    cycle(1, mk(11'd123, 16'h4567, 1'b1, 4'd9, 16'h2468), 0);
    chk("post_arst_head", 64'(hcount_ray_out), 64'(123));
    chk("post_arst_count", 64'(count_out), 64'(1));
    cycle(0, '0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dda_result_fifo.md
Name: dda_result_fifo

Overview:
- Elastic buffer between the DDA ray caster and the transformation stage.
- Each DDA result is captured as one 48-bit record: hcount_ray, lineHeight, wallType, mapData and wallX.
- Records are replayed in order to the transformation stage over a valid/ready handshake.
- The block absorbs rate mismatch between DDA (bursty, variable latency per ray) and the downstream renderer, and flags end-of-frame and overflow.

Parameters:
- DEPTH, 16, number of records stored; power of two, at least 4.
- SCREEN_WIDTH, 320, columns per frame; the last column index is SCREEN_WIDTH-1.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-high reset
- hcount_ray_in  in  11  ray column from DDA
- lineHeight_in  in  16  SCREEN_HEIGHT/perpWallDist
- wallType_in  in  1  0 = X-side hit, 1 = Y-side hit
- mapData_in  in  4  map cell value at hit
- wallX_in  in  16  hit position along wall
- ray_valid_in  in  1  DDA record present this cycle
- ray_ready_out  out  1  buffer can accept (not full)
- hcount_ray_out  out  11  head record column
- lineHeight_out  out  16  head record lineHeight
- wallType_out  out  1  head record wallType
- mapData_out  out  4  head record mapData
- wallX_out  out  16  head record wallX
- valid_out  out  1  head record valid
- ready_in  in  1  transformation stage accepts head
- count_out  out  $clog2(DEPTH)+1  records held
- frame_done_out  out  1  one-cycle pulse, last column of frame consumed
- overflow_out  out  1  sticky: a record was dropped

Behaviour:
- Reset (async, rst_in=1):
  - Pointers and count go to 0.
  - valid_out=0, ray_ready_out=1, frame_done_out=0, overflow_out=0.
  - Data outputs are 0; storage contents are don't-care.
  - Reset asserted mid-operation discards all held records immediately.
- Push:
  - Occurs on a rising edge when ray_valid_in && ray_ready_out.
  - The record is written at wr_ptr and wr_ptr increments modulo DEPTH.
  - ray_ready_out = (count < DEPTH), evaluated from registered count; it does not depend on ready_in (no combinational path from ready_in to ray_ready_out).
- Pop:
  - Occurs on a rising edge when valid_out && ready_in; rd_ptr increments modulo DEPTH.
- Output form: first-word-fall-through.
  - valid_out = (count != 0).
  - Data outputs show storage[rd_ptr] whenever valid_out=1 and are held stable until popped.
  - When valid_out=0, data outputs are don't-care; the bench must not check them.
- Latency: a record pushed on edge N is visible with valid_out=1 after edge N (next cycle). Minimum through-latency is 1 cycle.
- Simultaneous push and pop:
  - Both occur and count is unchanged.
  - When full, a pop and an attempted push in the same cycle: the push is refused, because ready was low at the start of the cycle.
  - When empty, only the push occurs; the pop is impossible since valid_out=0.
- Overflow:
  - ray_valid_in=1 while ray_ready_out=0 drops that record.
  - overflow_out sets the next cycle and stays 1 until reset.
  - Pointers and count are unaffected.
- Pop on empty (ready_in=1, valid_out=0): no effect.
- Pointer wrap: pointers are $clog2(DEPTH) bits wide and wrap naturally. count_out carries the full/empty distinction.
- Frame tracking: frame_done_out=1 for exactly one cycle after the edge on which a record with hcount_ray_out==SCREEN_WIDTH-1 is popped; otherwise 0.
- Record ordering is strict FIFO. No reordering or filtering by hcount.

Test Plan:
- Reset then single push (hcount=5, lineHeight=0x0120, wallType=1, mapData=3, wallX=0x8000) with ready_in=0 -> next cycle valid_out=1, outputs equal the pushed fields, count_out=1; after ready_in=1 for one cycle, valid_out=0, count_out=0.
- DEPTH=16: push 16 records (hcount 0..15) with ready_in=0 -> ray_ready_out=0 after the 16th push, count_out=16. A 17th push (hcount=99) sets overflow_out=1. Then drain -> hcount_out sequence 0..15, and 99 never appears.
- Continuous streaming with ray_valid_in=1 and ready_in=1 every cycle for 40 records -> count_out holds at 1 after the first push, output sequence is in order, pointers wrap twice, and overflow_out stays 0.
- SCREEN_WIDTH=320: push columns 317,318,319,0 and pop all -> frame_done_out pulses once, in the cycle after 319 is popped. No pulse for the others.
- Full FIFO with ready_in=1 and ray_valid_in=1 in the same cycle -> one pop, push refused, count_out=15, overflow_out=1.
- Assert rst_in asynchronously (between edges) with 7 records held -> valid_out=0, count_out=0, overflow_out=0 immediately. After release, a new push is the first record out.
